// File: rtl/mcs51_bus_slave_pkg.sv
// Shared definitions for the 8051 external-bus slave: FSM encodings, address width, write payload.
package mcs51_bus_slave_pkg;

    localparam int unsigned TH_ADDR_W = 16;
    localparam int unsigned TH_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ALE  = 3'd1,
        S_ADDR = 3'd2,
        S_WR   = 3'd3,
        S_RD   = 3'd4
    } state_e;

    typedef struct packed {
        logic [TH_ADDR_W-1:0] addr;
        logic [TH_DATA_W-1:0] data;
    } wr_payload_t;

    // Unsigned window test done in 17 bits so base+n never wraps past 16'hFFFF.
    function automatic logic in_window(input logic [TH_ADDR_W-1:0] a,
                                       input logic [TH_ADDR_W-1:0] base,
                                       input int unsigned n);
        return (17'(a) >= 17'(base)) && (17'(a) < (17'(base) + 17'(n)));
    endfunction

endpackage

// File: rtl/mcs51_bus_slave_if.sv
// 8051 external bus plus the decoded write/register outputs of the bus slave.
interface mcs51_bus_slave_if #(
    parameter int unsigned NREG = 8
);
    logic                cs_n;
    logic [7:0]          abus;
    logic                ale;
    logic                r_n;
    logic                w_n;
    logic [7:0]          dbus_in;
    logic [7:0]          dbus_out;
    logic                dbus_oe;
    logic                wr_en_n;
    logic [15:0]         wr_addr;
    logic [7:0]          wr_data;
    logic [NREG-1:0]     wr_pulse;
    logic [8*NREG-1:0]   reg_q;

    modport master (
        output cs_n, abus, ale, r_n, w_n, dbus_in,
        input  dbus_out, dbus_oe, wr_en_n, wr_addr, wr_data, wr_pulse, reg_q
    );

    modport slave (
        input  cs_n, abus, ale, r_n, w_n, dbus_in,
        output dbus_out, dbus_oe, wr_en_n, wr_addr, wr_data, wr_pulse, reg_q
    );
endinterface

// File: rtl/mcs51_bus_slave_sync_cell.sv
// STAGES-deep flop chain with a configurable reset value; used as synchroniser and alignment delay.
module mcs51_bus_slave_sync_cell #(
    parameter int unsigned W       = 1,
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] stg;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stg <= {STAGES{ {W{RST_VAL}} }};
        end else begin
            stg <= {stg[STAGES-2:0], d};
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/mcs51_bus_slave.sv
// 8051 external-bus slave: synchronised strobes, address latch, write strobe and local register window.
// Optional CPU read-back of local registers is enabled by defining MCS51_RDBACK_EN.
module mcs51_bus_slave
    import mcs51_bus_slave_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE   = 16'h8000,
    parameter int unsigned NREG        = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                rst_n,
    mcs51_bus_slave_if.slave    bus
);

    localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic        cs_s, ale_s, r_s, w_s;
    logic        ale_p, r_p, w_p;
    logic [15:0] bd_s;

    mcs51_bus_slave_sync_cell #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clock(clock), .rst_n(rst_n), .d(bus.cs_n), .q(cs_s));
    mcs51_bus_slave_sync_cell #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ale (
        .clock(clock), .rst_n(rst_n), .d(bus.ale), .q(ale_s));
    mcs51_bus_slave_sync_cell #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_r (
        .clock(clock), .rst_n(rst_n), .d(bus.r_n), .q(r_s));
    mcs51_bus_slave_sync_cell #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_w (
        .clock(clock), .rst_n(rst_n), .d(bus.w_n), .q(w_s));
    // Address/data bus delayed by the same depth so it lines up with the strobes.
    mcs51_bus_slave_sync_cell #(.W(16), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dly_bus (
        .clock(clock), .rst_n(rst_n), .d({bus.abus, bus.dbus_in}), .q(bd_s));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ale_p <= 1'b0;
            r_p   <= 1'b1;
            w_p   <= 1'b1;
        end else begin
            ale_p <= ale_s;
            r_p   <= r_s;
            w_p   <= w_s;
        end
    end

    logic cs, ale_rise, ale_fall, r_fall, r_rise, w_fall, w_rise;
    assign cs       = ~cs_s;
    assign ale_rise =  ale_s & ~ale_p;
    assign ale_fall = ~ale_s &  ale_p;
    assign r_fall   = ~r_s   &  r_p;
    assign r_rise   =  r_s   & ~r_p;
    assign w_fall   = ~w_s   &  w_p;
    assign w_rise   =  w_s   & ~w_p;

    state_e state, state_d;
    logic   commit, addr_ld;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Bus protocol sequencing; losing chip select abandons any transaction.
    always_comb begin
        state_d = state;
        commit  = 1'b0;
        addr_ld = 1'b0;
        if (!cs) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (ale_rise) state_d = S_ALE;
                S_ALE: begin
                    if (ale_fall) begin
                        addr_ld = 1'b1;
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_fall)        state_d = S_WR;
                    else if (r_fall)   state_d = S_RD;
                    else if (ale_rise) state_d = S_ALE;
                end
                S_WR: begin
                    if (w_rise) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_RD:    if (r_rise) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic [15:0]       addr_q;
    logic              hit;
    logic [IDX_W-1:0]  idx;
    wr_payload_t       wr_q;
    logic              wr_en_n_q;
    logic [NREG-1:0]   wr_pulse_q;
    logic [8*NREG-1:0] reg_q_q;

    assign hit = in_window(addr_q, ADDR_BASE, NREG);
    assign idx = IDX_W'(addr_q - ADDR_BASE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wr_q       <= '0;
            wr_en_n_q  <= 1'b1;
            wr_pulse_q <= '0;
            reg_q_q    <= '0;
        end else begin
            wr_en_n_q  <= ~commit;
            wr_pulse_q <= '0;
            if (addr_ld) addr_q <= bd_s;
            if (commit) begin
                wr_q.addr <= addr_q;
                wr_q.data <= bd_s[7:0];
                if (hit) begin
                    wr_pulse_q[idx]               <= 1'b1;
                    reg_q_q[8*int'(idx) +: 8]     <= bd_s[7:0];
                end
            end
        end
    end

    assign bus.wr_en_n  = wr_en_n_q;
    assign bus.wr_addr  = wr_q.addr;
    assign bus.wr_data  = wr_q.data;
    assign bus.wr_pulse = wr_pulse_q;
    assign bus.reg_q    = reg_q_q;

`ifdef MCS51_RDBACK_EN
    logic       oe_q;
    logic [7:0] dout_q;
    logic       rd_hit;

    assign rd_hit = (state_d == S_RD) && hit;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            oe_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            oe_q   <= rd_hit;
            dout_q <= rd_hit ? reg_q_q[8*int'(idx) +: 8] : 8'h00;
        end
    end

    assign bus.dbus_oe  = oe_q;
    assign bus.dbus_out = dout_q;
`else
    assign bus.dbus_oe  = 1'b0;
    assign bus.dbus_out = 8'h00;
`endif

endmodule

// File: tb/tb_mcs51_bus_slave.sv
// Scoreboard bench for mcs51_bus_slave: bus writes/reads, cs abort, mid-write reset, back-to-back writes.
module tb_mcs51_bus_slave;
    import mcs51_bus_slave_pkg::*;

    localparam int unsigned SS   = 2;
    localparam int unsigned NR   = 8;
    localparam logic [15:0] BASE = 16'h8000;
`ifdef MCS51_RDBACK_EN
    localparam bit RDBACK = 1'b1;
`else
    localparam bit RDBACK = 1'b0;
`endif

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    mcs51_bus_slave_if #(.NREG(NR)) bus ();

    mcs51_bus_slave #(.ADDR_BASE(BASE), .NREG(NR), .SYNC_STAGES(SS)) dut (
        .clock(clock), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  pulse;
        logic [63:0] regs;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hit(input logic [15:0] a);
        return (a >= BASE) && (32'(a) < 32'(BASE) + NR);
    endfunction

    // Every low wr_en_n cycle must match the oldest expected write.
    always @(posedge clock) begin
        #1;
        if (rst_n && bus.wr_en_n === 1'b0) begin
            check_eq("wr_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("wr_addr",  64'(bus.wr_addr),  64'(e.addr));
                check_eq("wr_data",  64'(bus.wr_data),  64'(e.data));
                check_eq("wr_pulse", 64'(bus.wr_pulse), 64'(e.pulse));
                check_eq("reg_q",    bus.reg_q,         e.regs);
                check_eq("wr_lat",   64'(cyc),          64'(e.cyc));
            end
        end
    end

    task automatic addr_phase(input logic [15:0] a);
        @(negedge clock);
        bus.cs_n = 1'b0; bus.ale = 1'b1; bus.abus = a[15:8]; bus.dbus_in = a[7:0];
        repeat (2) @(negedge clock);
        bus.ale = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input bit keep_cs);
        exp_t e;
        addr_phase(a);
        bus.dbus_in = d; bus.w_n = 1'b0;
        repeat (3) @(negedge clock);
        bus.w_n = 1'b1;
        e.addr = a; e.data = d; e.pulse = '0;
        if (is_hit(a)) begin
            e.pulse = 8'(1) << (a - BASE);
            model[8*int'(a - BASE) +: 8] = d;
        end
        e.regs = model;
        e.cyc  = cyc + int'(SS) + 1;
        exp_q.push_back(e);
        repeat (2) @(negedge clock);
        if (!keep_cs) bus.cs_n = 1'b1;
    endtask

    task automatic bus_read(input logic [15:0] a);
        logic       exp_oe;
        logic [7:0] exp_out;
        exp_oe  = RDBACK && is_hit(a);
        exp_out = exp_oe ? model[8*int'(a - BASE) +: 8] : 8'h00;
        addr_phase(a);
        bus.r_n = 1'b0;
        repeat (5) @(negedge clock);
        check_eq("rd_oe",  64'(bus.dbus_oe),  64'(exp_oe));
        check_eq("rd_out", 64'(bus.dbus_out), 64'(exp_out));
        bus.r_n = 1'b1;
        repeat (SS) @(posedge clock);
        #1 check_eq("rd_oe_hold", 64'(bus.dbus_oe), 64'(exp_oe));
        @(posedge clock);
        #1 check_eq("rd_oe_drop", 64'(bus.dbus_oe), 64'd0);
        @(negedge clock);
        bus.cs_n = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wr_en_n"},  64'(bus.wr_en_n),  64'd1);
        check_eq({tag, "_wr_addr"},  64'(bus.wr_addr),  64'd0);
        check_eq({tag, "_wr_data"},  64'(bus.wr_data),  64'd0);
        check_eq({tag, "_wr_pulse"}, 64'(bus.wr_pulse), 64'd0);
        check_eq({tag, "_reg_q"},    bus.reg_q,         64'd0);
        check_eq({tag, "_dbus_oe"},  64'(bus.dbus_oe),  64'd0);
        check_eq({tag, "_dbus_out"}, 64'(bus.dbus_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cs_n = 1'b1; bus.ale = 1'b0; bus.r_n = 1'b1; bus.w_n = 1'b1;
        bus.abus = 8'h00; bus.dbus_in = 8'h00;
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clock);

        // Local write, then a miss write.
        bus_write(16'h8003, 8'hA5, 1'b0);
        repeat (4) @(negedge clock);
        bus_write(16'h1234, 8'h5A, 1'b0);
        repeat (4) @(negedge clock);

        // Chip select lost mid-write: no commit, FSM idles.
        addr_phase(16'h8001);
        bus.dbus_in = 8'h77; bus.w_n = 1'b0;
        repeat (3) @(negedge clock);
        bus.cs_n = 1'b1;
        repeat (4) @(negedge clock);
        bus.w_n = 1'b1;
        repeat (4) @(negedge clock);
        check_eq("abort_state", 64'(dut.state), 64'(S_IDLE));
        check_eq("abort_reg_q", bus.reg_q, model);

        // Read-back of a hit and of a miss just past the window.
        bus_read(16'h8003);
        bus_read(16'h8008);

        // Back-to-back writes with cs held.
        bus_write(16'h8000, 8'h11, 1'b1);
        bus_write(16'h8007, 8'hEE, 1'b0);
        repeat (6) @(negedge clock);
        bus_read(16'h8007);

        // Reset while in the write state.
        addr_phase(16'h8002);
        bus.dbus_in = 8'h3C; bus.w_n = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("pre_rst_state", 64'(dut.state), 64'(S_WR));
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model = '0;
        @(negedge clock);
        rst_n = 1'b1; bus.w_n = 1'b1; bus.cs_n = 1'b1;
        repeat (4) @(negedge clock);
        bus_write(16'h8002, 8'hC3, 1'b0);
        repeat (8) @(negedge clock);

        check_eq("wr_outstanding", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
